// File: rtl/osc_meter_pkg.sv
// rtl/osc_meter_pkg.sv - shared FSM state, settle length and gate-window helpers
package osc_meter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      COUNT,
      DONE
   } meter_state_t;

   // Extra settle cycles beyond the synchroniser depth: one for the edge
   // detector history flop, one of margin for the mux switch.
   localparam int SETTLE_EXTRA = 2;

   function automatic int settle_cycles(input int sync_stages);
      return sync_stages + SETTLE_EXTRA;
   endfunction

   function automatic int win_cycles(input int win_base, input logic [1:0] win_sel);
      return 1 << (win_base + int'(win_sel));
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser followed by a rising-edge pulse
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/osc_freq_meter.sv
// rtl/osc_freq_meter.sv - gated rising-edge counter for a selectable ring-oscillator channel
module osc_freq_meter
   import osc_meter_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int CNT_W       = 16,
   parameter int WIN_BASE    = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         osc_in,
   input  logic [$clog2(NUM_CH)-1:0] ch_sel,
   input  logic [1:0]                win_sel,
   input  logic                      start,
   input  logic                      continuous,
   output logic [CNT_W-1:0]          result,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic                      overflow,
   output logic                      busy
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int WCW  = WIN_BASE + 4;

   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [WCW-1:0]   SETTLE_LAST = WCW'(settle_cycles(SYNC_STAGES) - 1);

   meter_state_t     state;
   logic [CH_W-1:0]  ch_q;
   logic [1:0]       win_q;
   logic             cont_q;
   logic [WCW-1:0]   win_cnt;
   logic [WCW-1:0]   win_last;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat;
   logic             edge_pulse;
   logic             at_max;

   // The synchroniser sees only the channel latched at start, never live ch_sel.
   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge_det (
      .clk  (clk),
      .rst  (rst),
      .din  (osc_in[ch_q]),
      .pulse(edge_pulse)
   );

   assign win_last = WCW'(win_cycles(WIN_BASE, win_q) - 1);
   assign at_max   = (edge_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ch_q         <= '0;
         win_q        <= '0;
         cont_q       <= 1'b0;
         win_cnt      <= '0;
         edge_cnt     <= '0;
         sat          <= 1'b0;
         result       <= '0;
         overflow     <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ch_q     <= ch_sel;
                  win_q    <= win_sel;
                  cont_q   <= continuous;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SETTLE;
               end
            end
            SETTLE: begin
               edge_cnt <= '0;
               sat      <= 1'b0;
               if (win_cnt == SETTLE_LAST) begin
                  win_cnt <= '0;
                  state   <= COUNT;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            COUNT: begin
               if (edge_pulse) begin
                  if (at_max) sat <= 1'b1;
                  else        edge_cnt <= edge_cnt + 1'b1;
               end
               // Fold the final cycle's edge straight into the published result.
               if (win_cnt == win_last) begin
                  result       <= (edge_pulse && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
                  overflow     <= sat | (edge_pulse & at_max);
                  result_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  if (cont_q) begin
                     ch_q     <= ch_sel;
                     win_q    <= win_sel;
                     cont_q   <= continuous;
                     win_cnt  <= '0;
                     edge_cnt <= '0;
                     sat      <= 1'b0;
                     state    <= SETTLE;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_osc_freq_meter.sv
// tb/tb_osc_freq_meter.sv - directed self-checking bench for osc_freq_meter
module tb_osc_freq_meter;

   localparam int NUM_CH      = 8;
   localparam int CNT_W       = 8;
   localparam int WIN_BASE    = 10;
   localparam int SYNC_STAGES = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       osc_in;
   logic [2:0]       ch_sel;
   logic [1:0]       win_sel;
   logic             start;
   logic             continuous;
   logic [CNT_W-1:0] result;
   logic             result_valid;
   logic             result_ready;
   logic             overflow;
   logic             busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] tick;

   osc_freq_meter #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .WIN_BASE   (WIN_BASE),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .osc_in      (osc_in),
      .ch_sel      (ch_sel),
      .win_sel     (win_sel),
      .start       (start),
      .continuous  (continuous),
      .result      (result),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Channel periods in clk cycles: 0 static low, 1:4, 2:8, 3:8, 4:32, 5:16, 6:64, 7 static high.
   initial begin
      tick   = '0;
      osc_in = '0;
      forever begin
         @(negedge clk);
         tick   = tick + 1;
         osc_in = {1'b1, tick[5], tick[3], tick[4], tick[2], tick[2], tick[1], 1'b0};
      end
   end

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [2:0] ch, input logic [1:0] win, input logic cont);
      ch_sel     = ch;
      win_sel    = win;
      continuous = cont;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (!result_valid && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      expect_eq({tag, "_valid"}, 32'(result_valid), 32'd1);
   endtask

   task automatic consume();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   initial begin
      int cyc;
      int bad;
      int seen;
      rst          = 1'b1;
      ch_sel       = '0;
      win_sel      = '0;
      start        = 1'b0;
      continuous   = 1'b0;
      result_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      expect_eq("rst_result", 32'(result), 32'd0);
      expect_eq("rst_valid", 32'(result_valid), 32'd0);
      expect_eq("rst_overflow", 32'(overflow), 32'd0);
      expect_eq("rst_busy", 32'(busy), 32'd0);

      // Static channel: no edges, fixed latency of window + settle.
      do_start(3'd0, 2'd0, 1'b0);
      expect_eq("static_busy", 32'(busy), 32'd1);
      wait_valid("static", 1200, cyc);
      expect_eq("static_latency", 32'(cyc), 32'd1028);
      expect_eq("static_result", 32'(result), 32'd0);
      expect_eq("static_overflow", 32'(overflow), 32'd0);
      consume();
      expect_eq("static_done_valid", 32'(result_valid), 32'd0);
      expect_eq("static_done_busy", 32'(busy), 32'd0);

      // Channel 3, period 8, 1024-cycle window.
      do_start(3'd3, 2'd0, 1'b0);
      wait_valid("ch3", 1200, cyc);
      expect_eq("ch3_result", 32'(result), 32'd128);
      expect_eq("ch3_overflow", 32'(overflow), 32'd0);

      // Back-pressure: result held, start pulses ignored.
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         ch_sel  = 3'd7;
         win_sel = 2'd3;
         start   = i[0];
         @(negedge clk);
         if (result !== 8'd128 || overflow !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b1)
            bad++;
      end
      start = 1'b0;
      expect_eq("hold_stable", 32'(bad), 32'd0);
      consume();
      expect_eq("hold_consumed_valid", 32'(result_valid), 32'd0);
      expect_eq("hold_consumed_busy", 32'(busy), 32'd0);
      expect_eq("hold_result_kept", 32'(result), 32'd128);

      // Saturation: period 4 over 4096 cycles is 1024 edges into 8 bits.
      do_start(3'd1, 2'd2, 1'b0);
      wait_valid("sat", 4300, cyc);
      expect_eq("sat_latency", 32'(cyc), 32'd4100);
      expect_eq("sat_result", 32'(result), 32'd255);
      expect_eq("sat_overflow", 32'(overflow), 32'd1);
      consume();
      expect_eq("sat_overflow_kept", 32'(overflow), 32'd1);

      // Continuous mode, channel switched 2 -> 5 at the re-arm.
      do_start(3'd2, 2'd0, 1'b1);
      wait_valid("cont1", 1200, cyc);
      expect_eq("cont1_result", 32'(result), 32'd128);
      expect_eq("cont1_overflow", 32'(overflow), 32'd0);
      ch_sel     = 3'd5;
      continuous = 1'b0;
      consume();
      expect_eq("cont_rearm_valid", 32'(result_valid), 32'd0);
      expect_eq("cont_rearm_busy", 32'(busy), 32'd1);
      wait_valid("cont2", 1200, cyc);
      expect_eq("cont2_result", 32'(result), 32'd64);
      consume();
      expect_eq("cont_stop_busy", 32'(busy), 32'd0);

      // Reset mid-COUNT aborts without a result.
      do_start(3'd3, 2'd0, 1'b0);
      repeat (300) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expect_eq("abort_busy", 32'(busy), 32'd0);
      expect_eq("abort_valid", 32'(result_valid), 32'd0);
      expect_eq("abort_result", 32'(result), 32'd0);
      expect_eq("abort_overflow", 32'(overflow), 32'd0);
      seen = 0;
      repeat (1100) begin
         @(negedge clk);
         if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      expect_eq("abort_quiet", 32'(seen), 32'd0);
      do_start(3'd5, 2'd1, 1'b0);
      wait_valid("after_abort", 2300, cyc);
      expect_eq("after_abort_latency", 32'(cyc), 32'd2052);
      expect_eq("after_abort_result", 32'(result), 32'd128);
      consume();

      // Widest window: 8192 cycles, period 64.
      do_start(3'd6, 2'd3, 1'b0);
      wait_valid("win3", 8500, cyc);
      expect_eq("win3_latency", 32'(cyc), 32'd8196);
      expect_eq("win3_result", 32'(result), 32'd128);
      expect_eq("win3_overflow", 32'(overflow), 32'd0);
      consume();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
